// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding request/ack transaction to instruction
// memory, a show-ahead FIFO toward decode, and PC register write control.
module fetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic        Clk_i,
   input  logic        Rst_i,
   input  logic        Start_i,
   input  logic [31:0] PC_i,
   output logic        PCWrite_o,
   output logic [31:0] NextPC_o,
   input  logic        Flush_i,
   input  logic [31:0] Target_i,
   output logic        IMemReq_o,
   output logic [31:0] IMemAddr_o,
   input  logic        IMemAck_i,
   input  logic [31:0] IMemData_i,
   output logic        Valid_o,
   input  logic        Ready_i,
   output logic [31:0] Instr_o,
   output logic [31:0] InstrPC_o,
   output logic [1:0]  State_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state;
   logic          req_q;
   logic [31:0]   req_addr;
   logic [31:0]   addr_inc;

   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;

   logic          push;
   logic          pop;
   logic          space_ok;

   // Decode handshake: an entry transfers on a cycle where Valid_o and Ready_i are
   // both high; Valid_o never depends on Ready_i, and a flush cancels the transfer.
   assign push     = (state == REQ) && IMemAck_i && !Flush_i;
   assign pop      = Valid_o && Ready_i && !Flush_i;
   assign addr_inc = req_addr + 32'd4;
   assign space_ok = count_next < DEPTH_C;

   always_comb begin
      count_next = count;
      if (Flush_i) count_next = '0;
      else         count_next = count + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_comb begin
      PCWrite_o = 1'b0;
      NextPC_o  = PC_i;
      if (Flush_i) begin
         PCWrite_o = 1'b1;
         NextPC_o  = Target_i;
      end else if (push) begin
         PCWrite_o = 1'b1;
         NextPC_o  = addr_inc;
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         state    <= IDLE;
         req_q    <= 1'b0;
         req_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!Flush_i && Start_i && space_ok) begin
                  state    <= REQ;
                  req_q    <= 1'b1;
                  req_addr <= PC_i;
               end
            end
            REQ: begin
               if (Flush_i) begin
                  // A redirect without the ack leaves the old request on the bus.
                  if (IMemAck_i) begin
                     state <= IDLE;
                     req_q <= 1'b0;
                  end else begin
                     state <= DROP;
                  end
               end else if (IMemAck_i) begin
                  if (Start_i && space_ok) begin
                     req_addr <= addr_inc;
                  end else begin
                     state <= IDLE;
                     req_q <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (IMemAck_i) begin
                  state <= IDLE;
                  req_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk_i) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= req_addr;
         fifo_instr[wr_ptr] <= IMemData_i;
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_pc    <= '0;
         head_instr <= '0;
      end else begin
         count <= count_next;
         if (Flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Head register shows the new oldest entry; it holds when the FIFO drains.
            if (count_next != '0) begin
               if (count == (AW+1)'(pop)) begin
                  head_pc    <= req_addr;
                  head_instr <= IMemData_i;
               end else begin
                  head_pc    <= fifo_pc[rd_ptr + AW'(pop)];
                  head_instr <= fifo_instr[rd_ptr + AW'(pop)];
               end
            end
         end
      end
   end

   assign IMemReq_o  = req_q;
   assign IMemAddr_o = req_addr;
   assign Valid_o    = (count != '0);
   assign Instr_o    = head_instr;
   assign InstrPC_o  = head_pc;
   assign State_o    = state;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly downstream of the PC register: it takes the current fetch address, runs a single-outstanding request/acknowledge transaction to instruction memory, and buffers returned instructions in a small show-ahead FIFO for the decode stage. It also drives the PC register's write-enable and next-PC value, so PC advances only when a fetch completes or a redirect occurs.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥ 2.
- Clk_i  in  1  clock; all logic on rising edge.
- Rst_i  in  1  reset; synchronous, active-high.
- Start_i  in  1  fetch enable; new requests start only while high.
- PC_i  in  32  current PC register value.
- PCWrite_o  out  1  write-enable to PC register.
- NextPC_o  out  32  value PC register loads when PCWrite_o = 1.
- Flush_i  in  1  redirect (taken branch/jump) from downstream.
- Target_i  in  32  redirect address, valid with Flush_i.
- IMemReq_o  out  1  instruction memory request, registered.
- IMemAddr_o  out  32  request address, registered, stable while IMemReq_o = 1.
- IMemAck_i  in  1  memory completes the request this cycle; data valid.
- IMemData_i  in  32  returned instruction word.
- Valid_o  out  1  FIFO head valid.
- Ready_i  in  1  decode accepts the head this cycle.
- Instr_o  out  32  head instruction.
- InstrPC_o  out  32  address of head instruction.

## Operation
- States: IDLE, REQ, DROP. Reset: IDLE, FIFO empty, IMemReq_o = 0, IMemAddr_o = 0, Valid_o = 0, Instr_o = 0, InstrPC_o = 0.
- IMemReq_o = 1 exactly in REQ and DROP; IMemAddr_o = latched ReqAddr.
- Space rule: after this cycle's push/pop, occupancy < DEPTH.
- IDLE → REQ when Start_i = 1, Flush_i = 0 and the space rule holds; ReqAddr ← PC_i.
- REQ with IMemAck_i = 1, Flush_i = 0: push {ReqAddr, IMemData_i}; PCWrite_o = 1, NextPC_o = ReqAddr + 4 (mod 2^32). Stay in REQ with ReqAddr ← ReqAddr + 4 if Start_i = 1 and space rule holds, else IDLE.
- REQ without ack, Flush_i = 0: hold everything.
- Flush_i = 1 (any state): FIFO cleared (pop and push this cycle ignored); PCWrite_o = 1, NextPC_o = Target_i.
  - REQ with ack this cycle, or IDLE: next state IDLE; restart follows normal IDLE rule next cycle from PC_i = Target_i.
  - REQ without ack: → DROP; ReqAddr unchanged (old request still held).
  - DROP: → DROP (stale request still pending).
- DROP: keep request; on IMemAck_i discard data, no push, PCWrite_o = 0 (unless Flush_i), → IDLE.
- Outside the above, PCWrite_o = 0, NextPC_o = PC_i.
- FIFO: show-ahead; Valid_o = (occupancy ≠ 0); Instr_o/InstrPC_o = head entry (hold last value when empty); pop when Valid_o & Ready_i & !Flush_i. Push and pop same cycle allowed at any occupancy.
- Start_i falling mid-request: outstanding request completes normally; no new request.
- Rst_i overrides everything, including an outstanding request (memory must tolerate an abandoned request).

## Timing
- PCWrite_o, NextPC_o combinational from state, IMemAck_i, Flush_i, Target_i, ReqAddr, PC_i.
- IMemAck_i may arrive in the first cycle IMemReq_o is high (zero wait state).
- Zero-wait memory, Ready_i = 1: first request one cycle after Start_i rises; one instruction pushed per cycle thereafter; pushed entry visible on Valid_o the cycle after ack.
- Flush to first request at Target_i: 2 cycles (IDLE then REQ) when no stale request; extra cycles in DROP equal remaining memory latency.
- Decode must sample Instr_o only when Valid_o = 1.

## Test plan
- Reset with Start_i = 1, PC_i = 0x0: IMemReq_o = 0 on reset cycle; then requests 0x0, 0x4, 0x8 back-to-back with zero-wait ack; Valid_o/InstrPC_o give 0x0, 0x4, 0x8 on consecutive cycles; PCWrite_o high each ack cycle.
- Ready_i = 0, DEPTH = 2: exactly two instructions buffered, IMemReq_o drops, PCWrite_o stays 0; raise Ready_i → fetch resumes at 0x8, no duplicates or gaps.
- 3-cycle memory latency, Flush_i with Target_i = 0x100 in latency cycle 2: FIFO empties, NextPC_o = 0x100, DROP holds old address until ack, ack data never appears on Valid_o, next request at 0x100.
- Flush_i coincident with IMemAck_i and Ready_i: acked word discarded, pop ignored, Valid_o = 0 next cycle, next request at Target_i two cycles later.
- ReqAddr = 0xFFFFFFFC acked: NextPC_o = 0x00000000, next request address 0x0.
- Rst_i asserted during REQ with ack pending: next cycle IDLE, IMemReq_o = 0, Valid_o = 0, later ack ignored.
